down_sample_sched_ctrl: RTL and testbench
=========================================

DOWN_SAMPLE_SCHED_CTRL -- requirements
Module: down_sample_sched_ctrl

Interface
REQ-001 Parameter NDIM, default 4: number of loop-nest dimensions; ctrl var 0 is outermost, ctrl var NDIM-1 is innermost.
REQ-002 Parameter CW, default 16: width of each ctrl var, extent, delay and II field.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous abort; returns the block to IDLE.
REQ-006 start  input  1  one-cycle request to begin one full loop-nest sweep.
REQ-007 cfg_extent  input  NDIM x CW  trip count per dimension; the value 0 is treated as 1.
REQ-008 cfg_delay  input  CW  cycles to wait between start acceptance and the first op.
REQ-009 cfg_ii  input  CW  initiation interval between ops; the value 0 is treated as 1.
REQ-010 op_en  output  1  wen/ren strobe for the unified-buffer port being sequenced.
REQ-011 ctrl_vars  output  NDIM x CW  current iteration indices; valid while op_en is high.
REQ-012 busy  output  1  high in DELAY and RUN.
REQ-013 done  output  1  one-cycle pulse after the final op.

Function
REQ-014 The block SHALL implement the states IDLE, DELAY, RUN and FIN.
REQ-015 In IDLE, start SHALL latch cfg_extent, cfg_delay and cfg_ii into internal registers; config inputs are ignored at all other times.
REQ-016 On accepting start, the block SHALL go to DELAY if the latched delay is greater than 0, else directly to RUN.
REQ-017 DELAY SHALL count the latched delay cycles, then go to RUN; the first op_en occurs exactly delay+1 cycles after the start edge.
REQ-018 In RUN, op_en SHALL pulse for one cycle every II cycles; with II=1, op_en stays high continuously.
REQ-019 Ctrl vars SHALL start at all-zero; after each op, the innermost var increments.
REQ-020 When a ctrl var reaches extent-1, it SHALL wrap to 0 and carry into the next-outer var (odometer order).
REQ-021 Total ops per sweep SHALL equal the product of the effective extents.
REQ-022 After the op with all ctrl vars at extent-1, the block SHALL enter FIN, pulse done for one cycle, then return to IDLE.
REQ-023 A start received outside IDLE SHALL be ignored; start in the same cycle as done SHALL also be ignored.
REQ-024 flush SHALL take priority over start and over all state transitions.
REQ-025 On flush, the next state SHALL be IDLE, counters SHALL clear, op_en SHALL be 0 from the next cycle, and no done pulse SHALL occur.
REQ-026 When op_en is low, ctrl_vars SHALL hold their last value.
REQ-027 All counters SHALL be CW-bit unsigned; the II and delay counters SHALL never wrap during a sweep.

Reset
REQ-028 While rst_n is low, the state SHALL be IDLE and op_en, busy, done and all ctrl_vars SHALL be 0; the latched config SHALL be 0.
REQ-029 Asserting rst_n mid-sweep SHALL abort immediately with no done pulse; after deassertion the block waits for a new start.

Configuration
REQ-030 Macro SCHED_CTRL_STALL_EN compiled in SHALL add input stall (1 bit); while stall is high, the DELAY, II and ctrl-var counters freeze and op_en is forced to 0.
REQ-031 An op suppressed by stall SHALL be issued on the first cycle stall is low.
REQ-032 Without SCHED_CTRL_STALL_EN, the stall port SHALL be absent and the schedule SHALL be purely time-based.

Verification
REQ-033 extent={1,4,64,64}, delay=0, II=1, start -> op_en high for 16384 consecutive cycles; ctrl_vars go (0,0,0,0)..(0,3,63,63); done pulses on cycle 16385.
REQ-034 extent={1,4,32,32}, delay=67, II=1 -> first op_en at cycle 68 after start; 4096 ops; busy high from cycle 1 through the last op.
REQ-035 extent={1,1,2,3}, II=3 -> op_en on cycles 1,4,7,10,13,16; ctrl_vars (..,0,0),(..,0,1),(..,0,2),(..,1,0),(..,1,1),(..,1,2); done on cycle 17.
REQ-036 extent={0,0,0,0}, delay=0 -> exactly one op at all-zero ctrl_vars, then done.
REQ-037 flush asserted at op 100 of REQ-033, then start -> no done pulse; the sweep restarts at all-zero ctrl_vars; a start applied mid-sweep has no effect.
REQ-038 With SCHED_CTRL_STALL_EN, II=1 and stall high for 5 cycles at op 10 -> op 10 issues after stall drops; total ops unchanged; done is delayed by 5 cycles.

Source files
------------

// File: rtl/down_sample_sched_ctrl.sv
// down_sample_sched_ctrl: sweeps an NDIM-deep loop nest in odometer order. It
// issues one op_en strobe every II cycles after an optional start delay, then
// pulses done for one cycle.
// Optional feature macro: SCHED_CTRL_STALL_EN adds a stall input that freezes
// the delay, II and ctrl-var counters and masks op_en.
//
// Handshake: start is a one-cycle request, and it is honoured only in IDLE
// with flush low. op_en is a strobe with no ready: each high cycle is exactly
// one op, and ctrl_vars are valid in that cycle. done is a one-cycle pulse
// that follows the final op. flush wins over everything.
module down_sample_sched_ctrl #(
  parameter int NDIM = 4,
  parameter int CW   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      start,
  input  logic [NDIM-1:0][CW-1:0]   cfg_extent,
  input  logic [CW-1:0]             cfg_delay,
  input  logic [CW-1:0]             cfg_ii,
`ifdef SCHED_CTRL_STALL_EN
  input  logic                      stall,
`endif
  output logic                      op_en,
  output logic [NDIM-1:0][CW-1:0]   ctrl_vars,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_next;

  // Configuration captured on start acceptance
  logic [NDIM-1:0][CW-1:0]   ext_r;
  logic [CW-1:0]             dly_r;
  logic [CW-1:0]             ii_r;

  // Working counters
  logic [CW-1:0]             dly_cnt;
  logic [CW-1:0]             ii_cnt;
  logic [NDIM-1:0][CW-1:0]   vars_r;

  // Derived values
  logic [NDIM-1:0][CW-1:0]   ext_eff;
  logic [NDIM-1:0]           wrap;
  logic [NDIM-1:0][CW-1:0]   vars_next;
  logic [CW-1:0]             ii_eff;
  logic                      stall_i;
  logic                      accept;
  logic                      op_fire;
  logic                      last_op;
  logic                      dly_done;
  logic                      ii_done;

`ifdef SCHED_CTRL_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  // Zero extents and zero II behave as one; a var wraps at its effective extent
  always_comb begin
    for (int i = 0; i < NDIM; i++) begin
      ext_eff[i] = (ext_r[i] == '0) ? CW'(1) : ext_r[i];
      wrap[i]    = (vars_r[i] == (ext_eff[i] - CW'(1)));
    end
  end

  assign ii_eff   = (ii_r == '0) ? CW'(1) : ii_r;
  assign accept   = (state == IDLE) && start && !flush;
  assign op_fire  = (state == RUN) && (ii_cnt == '0) && !stall_i;
  assign last_op  = op_fire && (&wrap);
  assign dly_done = (dly_cnt == (dly_r - CW'(1)));
  assign ii_done  = (ii_cnt == (ii_eff - CW'(1)));

  // Odometer increment: innermost var counts, a wrapped var carries outward
  always_comb begin
    logic carry;
    carry     = 1'b1;
    vars_next = vars_r;
    for (int i = NDIM - 1; i >= 0; i--) begin
      if (carry) begin
        if (wrap[i]) begin
          vars_next[i] = '0;
        end else begin
          vars_next[i] = vars_r[i] + CW'(1);
          carry        = 1'b0;
        end
      end
    end
  end

  // Next-state selection; flush overrides every transition
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (cfg_delay != '0) ? DELAY : RUN;
      end
      DELAY: begin
        if (!stall_i && dly_done) state_next = RUN;
      end
      RUN: begin
        if (last_op) state_next = FIN;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Capture the sweep configuration only when a start is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_r <= '0;
      dly_r <= '0;
      ii_r  <= '0;
    end else if (accept) begin
      ext_r <= cfg_extent;
      dly_r <= cfg_delay;
      ii_r  <= cfg_ii;
    end
  end

  // Delay, II and ctrl-var counters; a stall freezes them all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= '0;
      ii_cnt  <= '0;
      vars_r  <= '0;
    end else if (flush) begin
      dly_cnt <= '0;
      ii_cnt  <= '0;
      vars_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dly_cnt <= '0;
            ii_cnt  <= '0;
          end
        end
        DELAY: begin
          if (!stall_i) dly_cnt <= dly_done ? '0 : dly_cnt + CW'(1);
        end
        RUN: begin
          if (!stall_i) ii_cnt <= ii_done ? '0 : ii_cnt + CW'(1);
          // The final op wraps every var, so the next sweep begins at zero
          if (op_fire) vars_r <= vars_next;
        end
        FIN: begin
          ii_cnt <= '0;
        end
        default: begin
          dly_cnt <= '0;
          ii_cnt  <= '0;
        end
      endcase
    end
  end

  assign op_en     = op_fire;
  assign ctrl_vars = vars_r;
  assign busy      = (state == DELAY) || (state == RUN);
  assign done      = (state == FIN);
  assign state_dbg = state;

endmodule

// File: tb/tb_down_sample_sched_ctrl.sv
// Bench for down_sample_sched_ctrl: a table of sweep vectors with hand-computed
// op counts, first-op cycle and done cycle, plus hand-written flush and
// mid-sweep reset sequences. Cycle n is the n-th rising edge after the edge
// that samples start; outputs are sampled on the falling edge.
module tb_down_sample_sched_ctrl;
  localparam int NDIM = 4;
  localparam int CW   = 16;
  localparam int W    = NDIM * CW;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic                    clk;
  logic                    rst_n;
  logic                    flush;
  logic                    start;
  logic [NDIM-1:0][CW-1:0] cfg_extent;
  logic [CW-1:0]           cfg_delay;
  logic [CW-1:0]           cfg_ii;
  logic                    stall;
  logic                    op_en;
  logic [NDIM-1:0][CW-1:0] ctrl_vars;
  logic                    busy;
  logic                    done;
  logic [1:0]              state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string name;
    int    ext [4];
    int    dly;
    int    ii;
    int    step;       // effective II
    int    ops;
    int    first;      // cycle of the first op
    int    done_cyc;   // cycle in which done is high
    int    mid_start;  // cycle of an ignored start (0 = none)
    int    start_at_done;
    int    stall_cyc;  // first stalled cycle (0 = none)
    int    stall_len;
  } vec_t;

  vec_t vec_q[$];

  down_sample_sched_ctrl #(.NDIM(NDIM), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .start      (start),
    .cfg_extent (cfg_extent),
    .cfg_delay  (cfg_delay),
    .cfg_ii     (cfg_ii),
`ifdef SCHED_CTRL_STALL_EN
    .stall      (stall),
`endif
    .op_en      (op_en),
    .ctrl_vars  (ctrl_vars),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic vec_t mk(input string name, input int e0, input int e1, input int e2,
                              input int e3, input int dly, input int ii, input int step,
                              input int ops, input int first, input int done_cyc,
                              input int mid_start, input int start_at_done,
                              input int stall_cyc, input int stall_len);
    vec_t v;
    v.name = name;
    v.ext[0] = e0; v.ext[1] = e1; v.ext[2] = e2; v.ext[3] = e3;
    v.dly = dly; v.ii = ii; v.step = step; v.ops = ops; v.first = first;
    v.done_cyc = done_cyc; v.mid_start = mid_start; v.start_at_done = start_at_done;
    v.stall_cyc = stall_cyc; v.stall_len = stall_len;
    return v;
  endfunction

  function automatic int eff(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic set_cfg(input int e0, input int e1, input int e2, input int e3,
                         input int dly, input int ii);
    cfg_extent[0] = CW'(e0);
    cfg_extent[1] = CW'(e1);
    cfg_extent[2] = CW'(e2);
    cfg_extent[3] = CW'(e3);
    cfg_delay     = CW'(dly);
    cfg_ii        = CW'(ii);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Apply one table vector and score its full sweep
  task automatic run_vec(input vec_t v);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cv;
    logic [W-1:0] e;
    int k, first_seen, done_seen, seq_err, busy_err, op_cyc, quiet_err;
    for (int a = 0; a < eff(v.ext[0]); a++)
      for (int b = 0; b < eff(v.ext[1]); b++)
        for (int c = 0; c < eff(v.ext[2]); c++)
          for (int d = 0; d < eff(v.ext[3]); d++) begin
            e = '0;
            e[0*CW +: CW] = CW'(a);
            e[1*CW +: CW] = CW'(b);
            e[2*CW +: CW] = CW'(c);
            e[3*CW +: CW] = CW'(d);
            exp_q.push_back(e);
          end
    set_cfg(v.ext[0], v.ext[1], v.ext[2], v.ext[3], v.dly, v.ii);
    pulse_start();
    k = 0; first_seen = -1; done_seen = -1; seq_err = 0; busy_err = 0;
    for (int cyc = 1; cyc <= v.done_cyc + 20; cyc++) begin
      @(negedge clk);
      cv = ctrl_vars;
      if (op_en) begin
        op_cyc = v.first + k * v.step;
        if (v.stall_cyc != 0 && op_cyc >= v.stall_cyc) op_cyc += v.stall_len;
        if (first_seen < 0) first_seen = cyc;
        if (exp_q.size() == 0) seq_err++;
        else begin
          e = exp_q.pop_front();
          if (e !== cv || cyc != op_cyc) seq_err++;
        end
        k++;
      end
      if (busy !== (cyc < v.done_cyc)) busy_err++;
      if (v.stall_cyc != 0 && cyc + 1 == v.stall_cyc) stall = 1'b1;
      if (v.stall_cyc != 0 && cyc + 1 == v.stall_cyc + v.stall_len) stall = 1'b0;
      if (v.mid_start != 0 && cyc + 1 == v.mid_start) begin
        set_cfg(1, 1, 1, 1, 0, 1);
        start = 1'b1;
      end
      if (v.mid_start != 0 && cyc == v.mid_start) start = 1'b0;
      if (done) begin
        done_seen = cyc;
        break;
      end
    end
    stall = 1'b0;
    start = 1'b0;
    chk({v.name, "_ops"}, 64'(k), 64'(v.ops));
    chk({v.name, "_first_op"}, 64'(first_seen), 64'(v.first));
    chk({v.name, "_seq_errs"}, 64'(seq_err), 64'd0);
    chk({v.name, "_busy_errs"}, 64'(busy_err), 64'd0);
    chk({v.name, "_done_cycle"}, 64'(done_seen), 64'(v.done_cyc));
    if (v.start_at_done != 0) begin
      set_cfg(1, 1, 1, 1, 0, 1);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk({v.name, "_done_width"}, 64'(done), 64'd0);
    chk({v.name, "_idle_after"}, 64'(state_dbg), 64'(ST_IDLE));
    chk({v.name, "_vars_wrapped"}, 64'(ctrl_vars), 64'd0);
    if (v.start_at_done != 0) begin
      quiet_err = 0;
      repeat (4) begin
        @(negedge clk);
        if (busy !== 1'b0 || op_en !== 1'b0 || done !== 1'b0) quiet_err++;
      end
      chk({v.name, "_start_at_done_ignored"}, 64'(quiet_err), 64'd0);
    end
  endtask

  // Flush at op index 100 of the long sweep: no done, counters cleared
  task automatic flush_seq();
    logic [W-1:0] e;
    int k, hit, bad;
    set_cfg(1, 4, 64, 64, 0, 1);
    pulse_start();
    k = 0; hit = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (op_en) begin
        if (k == 100) begin
          e = '0;
          e[2*CW +: CW] = CW'(1);
          e[3*CW +: CW] = CW'(36);
          chk("flush_op100_vars", 64'(ctrl_vars), 64'(e));
          flush = 1'b1;
          hit = 1;
          break;
        end
        k++;
      end
    end
    chk("flush_reached_op100", 64'(hit), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_op_en_low", 64'(op_en), 64'd0);
    chk("flush_busy_low", 64'(busy), 64'd0);
    chk("flush_vars_clear", 64'(ctrl_vars), 64'd0);
    chk("flush_state_idle", 64'(state_dbg), 64'(ST_IDLE));
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || op_en !== 1'b0) bad++;
    end
    chk("flush_no_done", 64'(bad), 64'd0);
  endtask

  // Asynchronous reset in the middle of a sweep
  task automatic reset_seq();
    int bad;
    set_cfg(1, 1, 4, 4, 0, 1);
    pulse_start();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_op_en", 64'(op_en), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_vars", 64'(ctrl_vars), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || op_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rst_mid_stays_idle", 64'(bad), 64'd0);
  endtask

  // Main sequence
  initial begin
    rst_n = 1'b0; flush = 1'b0; start = 1'b0; stall = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);

    // name, ext0..3, delay, ii, step, ops, first, done, mid_start, start@done, stall_cyc, stall_len
    vec_q.push_back(mk("long_ii1",    1, 4, 64, 64,  0, 1, 1, 16384,  1, 16385, 0, 0, 0, 0));
    vec_q.push_back(mk("delay67",     1, 4, 32, 32, 67, 1, 1,  4096, 68,  4164, 0, 0, 0, 0));
    vec_q.push_back(mk("ii3",         1, 1,  2,  3,  0, 3, 3,     6,  1,    17, 5, 0, 0, 0));
    vec_q.push_back(mk("zero_ext",    0, 0,  0,  0,  0, 1, 1,     1,  1,     2, 0, 1, 0, 0));
    vec_q.push_back(mk("ii0_d1",      1, 1,  1,  1,  1, 0, 1,     1,  2,     3, 0, 0, 0, 0));
    vec_q.push_back(mk("mixed",       2, 1,  1,  2,  3, 2, 2,     4,  4,    11, 0, 0, 0, 0));
    vec_q.push_back(mk("outer_carry", 3, 2,  1,  1,  0, 1, 1,     6,  1,     7, 0, 0, 0, 0));
`ifdef SCHED_CTRL_STALL_EN
    vec_q.push_back(mk("stall5",      1, 1,  4,  4,  0, 1, 1,    16,  1,    22, 0, 0, 11, 5));
`endif

    repeat (3) @(negedge clk);
    chk("reset_op_en", 64'(op_en), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_vars", 64'(ctrl_vars), 64'd0);
    chk("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start_busy", 64'(busy), 64'd0);

    foreach (vec_q[i]) run_vec(vec_q[i]);
    flush_seq();
    run_vec(mk("after_flush", 1, 1, 2, 3, 0, 3, 3, 6, 1, 17, 7, 0, 0, 0));
    reset_seq();
    run_vec(mk("after_reset", 1, 1, 1, 2, 0, 1, 1, 2, 1, 3, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
